// File: rtl/sort_pipe_hs.sv
// sort_pipe_hs: W-stage valid/ready min/max extraction sorter; i_chi/i_desc in via i_valid/o_ready, o_y/o_idx/o_desc out via o_valid/i_ready, o_occ = busy stages
module sort_pipe_hs #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [M*N-1:0]               i_chi,
  input  logic                         i_desc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [W*N-1:0]               o_y,
  output logic [W*$clog2(M)-1:0]       o_idx,
  output logic                         o_desc,
  output logic [$clog2(W+1)-1:0]       o_occ
);
  localparam int IW = $clog2(M);
  localparam int OW = $clog2(W+1);
  logic [W:0]        stage_ready;
  logic              q_valid [W];
  logic [M*N-1:0]    q_val   [W];
  logic [M-1:0]      q_alive [W];
  logic              q_desc  [W];
  logic [W*N-1:0]    q_y     [W];
  logic [W*IW-1:0]   q_idx   [W];
  assign stage_ready[W] = i_ready;
  assign o_ready = stage_ready[0];
  for (genvar k = 0; k < W; k++) begin : g_stage
    logic              u_valid, u_desc, r_valid, r_desc;
    logic [M*N-1:0]    u_val, r_val;
    logic [M-1:0]      u_alive, r_alive, alive_n;
    logic [W*N-1:0]    u_y, r_y, y_n;
    logic [W*IW-1:0]   u_idx, r_idx, idx_n;
    logic [N-1:0]      best;
    logic [IW-1:0]     sel;
    logic              found;
    if (k == 0) begin : g_in
      assign {u_valid, u_val, u_alive, u_desc, u_y, u_idx} =
        {i_valid, i_chi, {M{1'b1}}, i_desc, {W*N{1'b0}}, {W*IW{1'b0}}};
    end else begin : g_up
      assign {u_valid, u_val, u_alive, u_desc, u_y, u_idx} =
        {q_valid[k-1], q_val[k-1], q_alive[k-1], q_desc[k-1], q_y[k-1], q_idx[k-1]};
    end
    assign stage_ready[k] = !r_valid || stage_ready[k+1];
    // strict comparison while scanning upward keeps the lowest index on ties
    always_comb begin
      best = '0;
      sel = '0;
      found = 1'b0;
      for (int j = 0; j < M; j++) begin
        if (u_alive[j] && (!found || (u_desc ? u_val[j*N +: N] > best : u_val[j*N +: N] < best))) begin
          found = 1'b1;
          best = u_val[j*N +: N];
          sel = IW'(j);
        end
      end
      alive_n = u_alive & ~(M'(1) << sel);
      y_n = u_y;
      y_n[k*N +: N] = best;
      idx_n = u_idx;
      idx_n[k*IW +: IW] = sel;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_val <= '0;
        r_alive <= '0;
        r_desc <= 1'b0;
        r_y <= '0;
        r_idx <= '0;
      end else begin
        if (stage_ready[k]) r_valid <= u_valid;
        if (u_valid && stage_ready[k]) begin
          r_val <= u_val;
          r_alive <= alive_n;
          r_desc <= u_desc;
          r_y <= y_n;
          r_idx <= idx_n;
        end
      end
    end
    assign q_valid[k] = r_valid;
    assign q_val[k] = r_val;
    assign q_alive[k] = r_alive;
    assign q_desc[k] = r_desc;
    assign q_y[k] = r_y;
    assign q_idx[k] = r_idx;
  end
  assign o_valid = q_valid[W-1];
  assign o_y = q_y[W-1];
  assign o_idx = q_idx[W-1];
  assign o_desc = q_desc[W-1];
  always_comb begin
    o_occ = '0;
    for (int i = 0; i < W; i++) o_occ = o_occ + OW'(q_valid[i]);
  end
endmodule

// File: doc/sort_pipe_hs.md
Name: sort_pipe_hs

Overview:
- Parametrised, flow-controlled successor to the fixed W-stage min-extraction sorter.
- Each pipeline stage extracts the extreme element (min, or max in descending mode) from the remaining live elements of an M-element vector.
- After W stages it emits the W smallest (or largest) values in order, together with their original input indices.
- Sits between a vector producer and a consumer. Both sides use valid/ready handshakes, so back-pressure stalls the pipeline without losing data.

Parameters:
- M, 8, number of input elements per vector (M >= 2).
- N, 8, element width in bits, unsigned.
- W, 4, number of sorted outputs and pipeline stages (1 <= W <= M).
- IW, $clog2(M), width of the index fields (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input vector valid.
- o_ready  out  1  sorter accepts the input vector this cycle.
- i_chi  in  M*N  packed input vector; element j is bits [j*N +: N].
- i_desc  in  1  per-vector mode: 0 = ascending (min first), 1 = descending (max first).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_y  out  W*N  sorted values; o_y[0] is the first extracted element.
- o_idx  out  W*IW  original input index of each o_y[k].
- o_desc  out  1  mode the result was sorted with.
- o_occ  out  $clog2(W+1)  number of occupied pipeline stages.

Behaviour:
- Reset: asserting rst asynchronously clears every stage valid bit, o_valid, o_y, o_idx, o_desc and o_occ to 0.
  - o_ready reads 1 once rst is released.
  - A vector in flight when rst asserts is discarded; no partial result is ever emitted.
- Stage payload:
  - all M values;
  - a per-element alive mask (all 1s at entry) and index;
  - the desc bit;
  - partial results y[0..k-1] and idx[0..k-1].
- Stage k combinationally selects the alive element with the smallest value (largest if desc). It then:
  - writes that value and its index into y[k]/idx[k];
  - clears the element's alive bit;
  - registers the updated payload.
- Tie-break: among equal values the lowest index wins, in both modes. The sort is therefore stable.
- Comparison is unsigned over N bits. Dead elements never win. Each stage has at least one alive element because W <= M.
- Handshake:
  - stage k register loads when its upstream valid is 1 and stage_ready[k] = !valid_q[k] || stage_ready[k+1];
  - stage_ready[W] = i_ready;
  - o_ready = stage_ready[0];
  - the ready chain is combinational (no skid buffers), giving full throughput of one vector per cycle.
- A transfer occurs when valid and ready are both 1. Data must not change while valid is held high and ready is low; the sorter never drops or duplicates a vector.
- Latency: a vector accepted at edge t appears at o_valid/o_y after edge t+W-1, i.e. in the same cycle the last stage register is loaded. Latency is constant W cycles with no stalls.
- o_y, o_idx and o_desc are the last stage registers. They hold stable while o_valid=1 and i_ready=0.
- o_occ = popcount of stage valid bits. It changes on each edge by +1, -1 or 0.
- Simultaneous accept and drain when the pipeline is full with i_ready=1: o_ready=1, so a new vector enters the same cycle the oldest leaves. o_occ is unchanged.
- i_desc changing between vectors is legal; each vector uses its own captured bit.
- W=M: the last stage still selects the sole remaining alive element. The output is then the full sort.

Test Plan:
- Reset and latency: M=8, N=8, W=4, i_chi={7,3,9,1,5,0,8,2} (elem0..7), i_desc=0, i_ready=1 -> 4 cycles later o_y={0,1,2,3}, o_idx={5,3,7,1}, o_desc=0, o_valid high for one cycle.
- Descending mode on the same vector with i_desc=1 -> o_y={9,8,7,5}, o_idx={2,6,0,4}.
- Ties: i_chi={4,4,4,4,1,1,4,4} ascending -> o_y={1,1,4,4}, o_idx={4,5,0,1}. The descending run -> o_idx={0,1,2,3}.
- Back-pressure:
  - stream 6 vectors back-to-back while holding i_ready=0 -> o_ready drops after 4 accepted vectors, o_occ=4, output frozen;
  - then release i_ready -> all 6 results emerge in order, values intact, one per cycle.
- Mid-flight reset: assert rst while o_occ=3 -> all outputs are 0 immediately (asynchronous). The next vector produces a correct result with no stale data.
- Extremes: all elements 8'hFF ascending -> o_y all FF, o_idx={0,1,2,3}. W=M=8 configuration with a random vector -> full ascending sort matches the reference model over 1000 random vectors under random i_valid/i_ready.
